// File: rtl/alu_pkg.sv
// alu_pkg: operation codes, FSM state type and shift-op helper shared by the ALU execution unit
package alu_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_SRA = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  function automatic logic is_shift(input logic [3:0] code);
    return code == ALU_SLL || code == ALU_SRL || code == ALU_SRA;
  endfunction
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational single-cycle ops; ports code/a/b in, y out; unknown and shift codes fall back to add
module alu_core
  import alu_pkg::*;
(
  input  logic [3:0]  code,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  always_comb
    y = code == ALU_AND ? a & b :
        code == ALU_OR  ? a | b :
        code == ALU_SUB ? a - b :
        code == ALU_SLT ? {31'd0, $signed(a) < $signed(b)} :
                          a + b;
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: valid/ready ALU with bit-serial shifter; ports clk, reset, in_valid/in_ready/alu_control/src_a/src_b in, out_valid/out_ready/result/zero out
module alu_exec_unit
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  alu_control,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero
);
  state_t      state;
  logic [3:0]  op;
  logic [4:0]  cnt;
  logic [31:0] core_y;
  logic [31:0] step;
  alu_core u_core (.code(alu_control), .a(src_a), .b(src_b), .y(core_y));
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  // result doubles as the shift register while in SHIFT; it is only presented in DONE
  always_comb
    step = op == ALU_SLL ? result << 1 :
           op == ALU_SRA ? {result[31], result[31:1]} :
                           result >> 1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      op     <= ALU_AND;
      cnt    <= 5'd0;
      result <= 32'd0;
      zero   <= 1'b1;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op <= alu_control;
          if (is_shift(alu_control)) begin
            result <= src_a;
            zero   <= src_a == 32'd0;
            cnt    <= src_b[4:0];
            state  <= src_b[4:0] == 5'd0 ? DONE : SHIFT;
          end else begin
            result <= core_y;
            zero   <= core_y == 32'd0;
            state  <= DONE;
          end
        end
        SHIFT: begin
          result <= step;
          zero   <= step == 32'd0;
          cnt    <= cnt - 5'd1;
          if (cnt == 5'd1) state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed self-checking bench for alu_exec_unit
module tb_alu_exec_unit;
  import alu_pkg::*;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  alu_control = 4'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        in_ready, out_valid, zero;
  logic [31:0] result;
  int n_cmp = 0;
  int n_bad = 0;
  alu_exec_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic issue(input string tag, input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    alu_control = code;
    src_a = a;
    src_b = b;
    @(negedge clk);
    in_valid = 1'b0;
    alu_control = ALU_SUB;
    src_a = ~a;
    src_b = ~b;
  endtask
  task automatic expect_result(input string tag, input logic [31:0] exp, input int lat);
    int l = 1;
    while (!out_valid && l < 100) begin
      @(negedge clk);
      l++;
    end
    check({tag, "_lat"}, 32'(l), 32'(lat));
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_res"}, result, exp);
    check({tag, "_zero"}, 32'(zero), 32'(exp == 32'd0));
  endtask
  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_rel_ready"}, 32'(in_ready), 32'd1);
  endtask
  task automatic run(input string tag, input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat);
    issue(tag, code, a, b);
    expect_result(tag, exp, lat);
    release_out(tag);
  endtask
  initial begin
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    reset = 1'b0;
    run("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    run("slt_neg", ALU_SLT, 32'hFFFF_FFFE, 32'd3, 32'd1, 1);
    run("slt_false", ALU_SLT, 32'd3, 32'hFFFF_FFFE, 32'd0, 1);
    run("sub_eq", ALU_SUB, 32'd5, 32'd5, 32'd0, 1);
    run("sub_wrap", ALU_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1);
    run("and", ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1);
    run("or", ALU_OR, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1);
    run("sra31", ALU_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 32);
    run("srl31", ALU_SRL, 32'h8000_0000, 32'd31, 32'd1, 32);
    run("sll4", ALU_SLL, 32'd3, 32'd4, 32'h30, 5);
    run("sra_pos", ALU_SRA, 32'h4000_0000, 32'd2, 32'h1000_0000, 3);
    run("undef", 4'b1111, 32'd7, 32'd8, 32'd15, 1);
    issue("sll0", ALU_SLL, 32'd1, 32'h0000_0020);
    expect_result("sll0", 32'd1, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      alu_control = ALU_ADD;
      src_a = 32'd100;
      src_b = 32'd100;
      @(negedge clk);
      check("hold_res", result, 32'd1);
      check("hold_ready", 32'(in_ready), 32'd0);
      check("hold_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    release_out("sll0");
    @(negedge clk);
    check("no_queue", 32'(out_valid), 32'd0);
    issue("mid_rst", ALU_SLL, 32'd1, 32'd10);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_res", result, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("post_rst_idle", 32'(out_valid), 32'd0);
    end
    run("add_after_rst", ALU_ADD, 32'd2, 32'd3, 32'd5, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
